fix_tx_packer: RTL and testbench

Transmit-side bridge between the FIX engine and the TOE packet generator. It accepts the engine's outbound byte stream, finds message boundaries from the FIX trailer, and packs each message into 64-bit Avalon-ST beats carrying start, end and empty markers. It mirrors the receive-side interface block, which unpacks TOE data into bytes for the engine.

---
 rtl/fix_pkg.sv | 22 ++
 rtl/fix_trailer_det.sv | 65 ++++++
 rtl/fix_tx_packer.sv | 149 ++++++++++++++
 tb/tb_fix_tx_packer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared definitions for the FIX transmit packer: trailer states, byte constants
// and beat geometry.
package fix_pkg;

    typedef enum logic [2:0] {
        TRL_IDLE,
        TRL_BODY,
        TRL_SOH,
        TRL_T1,
        TRL_T10,
        TRL_CKS,
        TRL_DROP
    } trailer_state_t;

    localparam logic [7:0] SOH      = 8'h01;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/fix_trailer_det.sv
// Tracks the FIX "SOH 10=xxx SOH" trailer on the accepted byte stream and reports
// message start and termination.
module fix_trailer_det
    import fix_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           byte_valid,
    input  logic [7:0]     byte_data,
    input  logic           force_drop,
    output trailer_state_t state,
    output logic           at_start,
    output logic           terminate
);

    trailer_state_t state_reg;
    trailer_state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= TRL_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        at_start   = byte_valid && (state_reg == TRL_IDLE);
        terminate  = byte_valid && (state_reg == TRL_CKS) && (byte_data == SOH);

        if (byte_valid) begin
            case (state_reg)
                TRL_IDLE: state_next = (byte_data == ASCII_1) ? TRL_T1 : TRL_BODY;
                TRL_BODY: state_next = (byte_data == SOH) ? TRL_SOH : TRL_BODY;
                TRL_SOH: begin
                    if (byte_data == ASCII_1)  state_next = TRL_T1;
                    else if (byte_data == SOH) state_next = TRL_SOH;
                    else                       state_next = TRL_BODY;
                end
                TRL_T1: begin
                    if (byte_data == ASCII_0)  state_next = TRL_T10;
                    else if (byte_data == SOH) state_next = TRL_SOH;
                    else                       state_next = TRL_BODY;
                end
                TRL_T10: begin
                    if (byte_data == ASCII_EQ) state_next = TRL_CKS;
                    else if (byte_data == SOH) state_next = TRL_SOH;
                    else                       state_next = TRL_BODY;
                end
                TRL_CKS:  state_next = (byte_data == SOH) ? TRL_IDLE : TRL_CKS;
                TRL_DROP: state_next = (byte_data == SOH) ? TRL_IDLE : TRL_DROP;
                default:  state_next = TRL_IDLE;
            endcase

            // A genuine termination on the last allowed byte is a normal end, not a truncation.
            if (force_drop && !terminate) begin
                state_next = TRL_DROP;
            end
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/fix_tx_packer.sv
// Packs the FIX engine's outbound byte stream into 64-bit Avalon-ST beats with
// start/end/empty markers, closing words on the FIX trailer or on truncation.
module fix_tx_packer
    import fix_pkg::*;
#(
    parameter int MAX_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_i,
    input  logic [7:0]  data_i,
    output logic        full_o,
    output logic        start_pkt_o,
    output logic        end_pkt_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] packet_o,
    output logic [2:0]  empty_o,
    output logic        error_o
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    trailer_state_t trl_state;
    logic           at_start;
    logic           terminate;

    logic           accept;
    logic           place;
    logic           trunc;
    logic           close_word;
    logic           load;
    logic           asm_complete;
    logic [2:0]     write_idx;
    logic [2:0]     empty_calc;
    logic [63:0]    asm_word;

    logic [3:0]     asm_cnt_reg;
    logic           asm_start_reg;
    logic           asm_end_reg;
    logic           asm_err_reg;
    logic [7:0]     slot_reg [BEAT_BYTES];
    logic [CNT_W-1:0] msg_cnt_reg;

    logic           valid_reg;
    logic           start_reg;
    logic           end_reg;
    logic           err_reg;
    logic [63:0]    packet_reg;
    logic [2:0]     empty_reg;

    assign asm_complete = (asm_cnt_reg == 4'(BEAT_BYTES)) || asm_end_reg;
    assign load         = asm_complete && (!valid_reg || ready_i);
    assign full_o       = asm_complete && valid_reg && !ready_i;
    assign accept       = write_i && !full_o;
    // Bytes swallowed while dropping a truncated tail are accepted but never placed.
    assign place        = accept && (trl_state != TRL_DROP);
    assign trunc        = place && !terminate && (msg_cnt_reg == CNT_W'(MAX_BYTES - 1));
    assign close_word   = terminate || trunc;
    assign write_idx    = load ? 3'd0 : asm_cnt_reg[2:0];
    assign empty_calc   = 3'(4'(BEAT_BYTES) - asm_cnt_reg);

    fix_trailer_det u_trailer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept),
        .byte_data  (data_i),
        .force_drop (trunc),
        .state      (trl_state),
        .at_start   (at_start),
        .terminate  (terminate)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_cnt_reg <= '0;
        end else if (place) begin
            msg_cnt_reg <= close_word ? '0 : msg_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_cnt_reg   <= '0;
            asm_start_reg <= 1'b0;
            asm_end_reg   <= 1'b0;
            asm_err_reg   <= 1'b0;
        end else if (load) begin
            // The outgoing word frees the register; a byte arriving now starts the next one.
            asm_cnt_reg   <= place ? 4'd1 : 4'd0;
            asm_start_reg <= place && at_start;
            asm_end_reg   <= place && close_word;
            asm_err_reg   <= trunc;
        end else if (place) begin
            asm_cnt_reg <= asm_cnt_reg + 4'd1;
            if (at_start)   asm_start_reg <= 1'b1;
            if (close_word) asm_end_reg   <= 1'b1;
            if (trunc)      asm_err_reg   <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEAT_BYTES; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg[gi] <= '0;
                end else if (place && (write_idx == 3'(gi))) begin
                    slot_reg[gi] <= data_i;
                end else if (load) begin
                    slot_reg[gi] <= '0;
                end
            end
            assign asm_word[63 - 8*gi -: 8] = slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            start_reg  <= 1'b0;
            end_reg    <= 1'b0;
            err_reg    <= 1'b0;
            packet_reg <= '0;
            empty_reg  <= '0;
        end else if (load) begin
            valid_reg  <= 1'b1;
            start_reg  <= asm_start_reg;
            end_reg    <= asm_end_reg;
            err_reg    <= asm_err_reg;
            packet_reg <= asm_word;
            empty_reg  <= asm_end_reg ? empty_calc : 3'd0;
        end else if (ready_i) begin
            valid_reg <= 1'b0;
            start_reg <= 1'b0;
            end_reg   <= 1'b0;
            err_reg   <= 1'b0;
            empty_reg <= '0;
        end
    end

    assign valid_o     = valid_reg;
    assign start_pkt_o = start_reg;
    assign end_pkt_o   = end_reg;
    assign error_o     = err_reg;
    assign packet_o    = packet_reg;
    assign empty_o     = empty_reg;

endmodule

// File: tb/tb_fix_tx_packer.sv
// Scoreboard bench for fix_tx_packer: a default instance and a MAX_BYTES=16 instance
// share stimulus; sel picks which one the monitor observes.
module tb_fix_tx_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        ready_i = 1'b1;
    logic        sel = 1'b0;

    logic        full_a, start_a, end_a, valid_a, err_a;
    logic [63:0] pkt_a;
    logic [2:0]  empty_a;
    logic        full_b, start_b, end_b, valid_b, err_b;
    logic [63:0] pkt_b;
    logic [2:0]  empty_b;

    logic        m_full, m_start, m_end, m_valid, m_err;
    logic [63:0] m_pkt;
    logic [2:0]  m_empty;

    always #5 clk = ~clk;

    fix_tx_packer dut (
        .clk(clk), .rst(rst), .write_i(write_i), .data_i(data_i), .full_o(full_a),
        .start_pkt_o(start_a), .end_pkt_o(end_a), .valid_o(valid_a), .ready_i(ready_i),
        .packet_o(pkt_a), .empty_o(empty_a), .error_o(err_a)
    );

    fix_tx_packer #(.MAX_BYTES(16)) dut_t (
        .clk(clk), .rst(rst), .write_i(write_i), .data_i(data_i), .full_o(full_b),
        .start_pkt_o(start_b), .end_pkt_o(end_b), .valid_o(valid_b), .ready_i(ready_i),
        .packet_o(pkt_b), .empty_o(empty_b), .error_o(err_b)
    );

    assign m_full  = sel ? full_b  : full_a;
    assign m_start = sel ? start_b : start_a;
    assign m_end   = sel ? end_b   : end_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_err   = sel ? err_b   : err_a;
    assign m_pkt   = sel ? pkt_b   : pkt_a;
    assign m_empty = sel ? empty_b : empty_a;

    typedef struct packed {
        logic [63:0] pkt;
        logic        s;
        logic        e;
        logic        err;
        logic [2:0]  emp;
    } beat_t;

    beat_t       exp_q[$];
    int          beat_cyc[$];
    logic [7:0]  msg_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    int          err_beats = 0;
    beat_t       last_beat;
    logic        prev_stall = 1'b0;
    logic [63:0] held_pkt;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every transferred beat is compared to the next expected one.
    always @(negedge clk) begin : monitor
        beat_t x;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_valid || m_pkt !== held_pkt) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b packet_o=%h, required valid=1 packet_o=%h", m_valid, m_pkt, held_pkt);
                end
            end
            prev_stall = m_valid && !ready_i;
            held_pkt   = m_pkt;
            if (m_valid && ready_i) begin
                beats_seen++;
                beat_cyc.push_back(cyc);
                if (m_err) err_beats++;
                last_beat = '{pkt: m_pkt, s: m_start, e: m_end, err: m_err, emp: m_empty};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: packet_o=%h start=%0b end=%0b, required no beat", m_pkt, m_start, m_end);
                end else begin
                    x = exp_q.pop_front();
                    if (last_beat !== x) begin
                        errors++;
                        $display("FAIL beat: pkt=%h s=%0b e=%0b err=%0b emp=%0d, required pkt=%h s=%0b e=%0b err=%0b emp=%0d",
                                 m_pkt, m_start, m_end, m_err, m_empty, x.pkt, x.s, x.e, x.err, x.emp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; write_i = 1'b0; ready_i = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    // Expected beats: first maxb bytes in 8-byte chunks; truncated messages end with error.
    task automatic push_expected(input int maxb);
        int    n;
        int    k;
        beat_t b;
        n = (msg_q.size() > maxb) ? maxb : msg_q.size();
        for (int i = 0; i < n; i += 8) begin
            b = '0;
            k = 0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < n) begin
                    b.pkt[63 - 8*j -: 8] = msg_q[i + j];
                    k++;
                end
            end
            b.s   = (i == 0);
            b.e   = (i + 8 >= n);
            b.emp = b.e ? 3'(8 - k) : 3'd0;
            b.err = b.e && (msg_q.size() > maxb);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        write_i = 1'b1;
        data_i  = b;
        @(negedge clk);
        while (m_full && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            checks++; errors++;
            $display("FAIL send_timeout: full_o=%0b, required 0 within 300 cycles", m_full);
        end
        @(posedge clk);
        #1;
        write_i = 1'b0;
    endtask

    task automatic send_msg();
        for (int i = 0; i < msg_q.size(); i++) send_byte(msg_q[i]);
        msg_q = {};
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            tick();
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
            exp_q = {};
        end
        tick(); tick();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks += 7;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: %0b, required 0", m_valid); end
        if (m_start !== 1'b0) begin errors++; $display("FAIL reset_start: %0b, required 0", m_start); end
        if (m_end !== 1'b0)   begin errors++; $display("FAIL reset_end: %0b, required 0", m_end); end
        if (m_err !== 1'b0)   begin errors++; $display("FAIL reset_error: %0b, required 0", m_err); end
        if (m_pkt !== 64'd0)  begin errors++; $display("FAIL reset_packet: %h, required 0", m_pkt); end
        if (m_empty !== 3'd0) begin errors++; $display("FAIL reset_empty: %0d, required 0", m_empty); end
        if (m_full !== 1'b0)  begin errors++; $display("FAIL reset_full: %0b, required 0", m_full); end
        $display("test_reset: outputs sampled in reset");
    endtask

    task automatic test_single();
        int b0;
        do_reset();
        b0 = beats_seen;
        add_str("10=000"); msg_q.push_back(8'h01);
        push_expected(512);
        send_msg();
        drain();
        checks += 2;
        if (beats_seen - b0 !== 1) begin errors++; $display("FAIL single_count: %0d beats, required 1", beats_seen - b0); end
        if (last_beat !== {64'h31303D3030300100, 1'b1, 1'b1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL single_beat: pkt=%h s=%0b e=%0b emp=%0d, required pkt=31303d3030300100 s=1 e=1 emp=1",
                     last_beat.pkt, last_beat.s, last_beat.e, last_beat.emp);
        end
        $display("test_single: %0d beat(s), packet %h", beats_seen - b0, last_beat.pkt);
    endtask

    task automatic test_two_beats();
        int b0;
        do_reset();
        b0 = beats_seen;
        add_str("8=FIX.4."); msg_q.push_back(8'h01); add_str("10=123"); msg_q.push_back(8'h01);
        push_expected(512);
        send_msg();
        drain();
        checks += 2;
        if (beats_seen - b0 !== 2) begin errors++; $display("FAIL two_count: %0d beats, required 2", beats_seen - b0); end
        if (!last_beat.e || last_beat.emp !== 3'd0) begin
            errors++; $display("FAIL two_last: end=%0b empty=%0d, required end=1 empty=0", last_beat.e, last_beat.emp);
        end
        $display("test_two_beats: %0d beat(s)", beats_seen - b0);
    endtask

    task automatic test_backpressure();
        int   b0;
        logic full_seen;
        do_reset();
        b0 = beats_seen;
        full_seen = 1'b0;
        ready_i = 1'b0;
        for (int i = 0; i < 12; i++) msg_q.push_back(8'h42 + 8'(i));
        msg_q.push_back(8'h01); add_str("10=123"); msg_q.push_back(8'h01);
        push_expected(512);
        fork
            send_msg();
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (m_full) full_seen = 1'b1;
                end
                @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();
        checks += 2;
        if (full_seen !== 1'b1) begin errors++; $display("FAIL bp_full: full_o seen=%0b, required 1", full_seen); end
        if (beats_seen - b0 !== 3) begin errors++; $display("FAIL bp_count: %0d beats, required 3", beats_seen - b0); end
        $display("test_backpressure: full_seen=%0b beats=%0d", full_seen, beats_seen - b0);
    endtask

    task automatic test_truncation();
        int b0;
        int e0;
        sel = 1'b1;
        do_reset();
        b0 = beats_seen;
        e0 = err_beats;
        for (int i = 0; i < 20; i++) msg_q.push_back(8'h41 + 8'(i));
        msg_q.push_back(8'h01);
        push_expected(16);
        send_msg();
        add_str("10=000"); msg_q.push_back(8'h01);
        push_expected(16);
        send_msg();
        drain();
        checks += 3;
        if (beats_seen - b0 !== 3) begin errors++; $display("FAIL trunc_count: %0d beats, required 3", beats_seen - b0); end
        if (err_beats - e0 !== 1) begin errors++; $display("FAIL trunc_errors: %0d error beats, required 1", err_beats - e0); end
        if (!last_beat.s || !last_beat.e || last_beat.err) begin
            errors++; $display("FAIL trunc_next: s=%0b e=%0b err=%0b, required s=1 e=1 err=0", last_beat.s, last_beat.e, last_beat.err);
        end
        $display("test_truncation: beats=%0d error_beats=%0d", beats_seen - b0, err_beats - e0);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int b0;
        do_reset();
        ready_i = 1'b0;
        add_str("8=FIX.4.2ABCD");
        send_msg();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_valid, m_start, m_end, m_err, m_pkt, m_empty, m_full} !== '0) begin
            errors++;
            $display("FAIL mid_reset: valid=%0b start=%0b end=%0b err=%0b pkt=%h empty=%0d full=%0b, required all 0",
                     m_valid, m_start, m_end, m_err, m_pkt, m_empty, m_full);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_i = 1'b1;
        tick();
        b0 = beats_seen;
        add_str("10=000"); msg_q.push_back(8'h01);
        push_expected(512);
        send_msg();
        drain();
        checks++;
        if (beats_seen - b0 !== 1 || !last_beat.s || !last_beat.e) begin
            errors++;
            $display("FAIL mid_next: beats=%0d s=%0b e=%0b, required beats=1 s=1 e=1", beats_seen - b0, last_beat.s, last_beat.e);
        end
        $display("test_reset_mid: following message gave %0d beat(s)", beats_seen - b0);
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset();
        c0 = beat_cyc.size();
        for (int i = 0; i < 16; i++) msg_q.push_back(8'h61 + 8'(i));
        msg_q.push_back(8'h01); add_str("10=123"); msg_q.push_back(8'h01);
        push_expected(512);
        send_msg();
        drain();
        checks++;
        if (beat_cyc.size() - c0 !== 3) begin
            errors++; $display("FAIL b2b_count: %0d beats, required 3", beat_cyc.size() - c0);
        end else begin
            checks += 2;
            if (beat_cyc[c0+1] - beat_cyc[c0] !== 8) begin
                errors++; $display("FAIL b2b_gap1: %0d cycles, required 8", beat_cyc[c0+1] - beat_cyc[c0]);
            end
            if (beat_cyc[c0+2] - beat_cyc[c0+1] !== 8) begin
                errors++; $display("FAIL b2b_gap2: %0d cycles, required 8", beat_cyc[c0+2] - beat_cyc[c0+1]);
            end
        end
        $display("test_back_to_back: %0d beats", beat_cyc.size() - c0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_two_beats();
        test_backpressure();
        test_truncation();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
